// File: rtl/bcd_disp_pkg.sv
// Shared constants for the BCD counter/display block: active-low 7-segment
// glyphs (bit 6 = seg a ... bit 0 = seg g) and BCD limits.
package bcd_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BCD_MAX   = 4'd9;

  // Saturate a nibble into the legal BCD range.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// One-digit BCD to active-low 7-segment decoder; non-BCD codes go dark.
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_counter_display.sv
// Multi-digit BCD up/down counter with prescaler, parallel load, wrap pulse
// and per-digit 7-segment outputs. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module bcd_counter_display
  import bcd_disp_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int DIV    = 1
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic [7*DIGITS-1:0]   hex
);

  logic                tick;
  logic                ripple;
  logic [4*DIGITS-1:0] stepped;
  logic [4*DIGITS-1:0] loaded;
  logic [7*DIGITS-1:0] seg_raw;

  // Prescaler: a load restarts the step period so the loaded value is held a full period.
  generate
    if (DIV > 1) begin : g_pre
      localparam int PW = $clog2(DIV);
      localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
      logic [PW-1:0] pre;

      always_ff @(posedge CLOCK_50) begin
        if (reset || load) begin
          pre <= '0;
        end else if (en) begin
          pre <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
        end
      end

      assign tick = en && (pre == PRE_LAST);
    end else begin : g_nopre
      assign tick = en;
    end
  endgenerate

  // Ripple carry/borrow across digits; ripple left set means every digit rolled over.
  always_comb begin
    stepped = count;
    ripple  = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (ripple) begin
        if (up) begin
          if (count[4*k +: 4] == BCD_MAX) begin
            stepped[4*k +: 4] = 4'd0;
          end else begin
            stepped[4*k +: 4] = count[4*k +: 4] + 4'd1;
            ripple            = 1'b0;
          end
        end else begin
          if (count[4*k +: 4] == 4'd0) begin
            stepped[4*k +: 4] = BCD_MAX;
          end else begin
            stepped[4*k +: 4] = count[4*k +: 4] - 4'd1;
            ripple            = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    loaded = '0;
    for (int k = 0; k < DIGITS; k++) begin
      loaded[4*k +: 4] = bcd_clamp(load_val[4*k +: 4]);
    end
  end

  // Count register stage
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= loaded;
      wrap  <= 1'b0;
    end else if (tick) begin
      count <= stepped;
      wrap  <= ripple;
    end else begin
      wrap  <= 1'b0;
    end
  end

  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_dec
      bcd_to_7seg u_dec (
        .bcd (count[4*k +: 4]),
        .seg (seg_raw[7*k +: 7])
      );
    end
  endgenerate

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the top digit; blanking stops at the first nonzero digit.
  always_comb begin
    logic lead;
    hex  = seg_raw;
    lead = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      lead = lead && (count[4*k +: 4] == 4'd0);
      if (lead) begin
        hex[7*k +: 7] = SEG_BLANK;
      end
    end
  end
`else
  assign hex = seg_raw;
`endif

endmodule

// File: doc/bcd_counter_display.md
Name: bcd_counter_display

Overview:
Parametrised multi-digit BCD up/down counter with a built-in per-digit 7-segment decoder and a clock-enable prescaler. Successor to the single-digit switch-driven decoder: digit count, step rate and direction are configurable, and the block adds parallel load and a wrap pulse. Sits between board inputs (switches/keys) and the HEX displays on the DE2 top level.

Parameters:
DIGITS, 2, number of BCD digits / HEX displays driven (1..8)
DIV, 1, clock cycles per count step (1 = step every enabled cycle; max 2^26)

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
en  in  1  count enable; gates prescaler and stepping
up  in  1  direction: 1 = increment, 0 = decrement
load  in  1  synchronous parallel load strobe
load_val  in  4*DIGITS  BCD load value, digit 0 in bits [3:0]
count  out  4*DIGITS  registered BCD count, digit 0 in bits [3:0]
wrap  out  1  one-cycle pulse on wrap-around (carry or borrow)
hex  out  7*DIGITS  active-low segments, digit k in bits [7k+6:7k], within each digit bit 6 = seg a ... bit 0 = seg g

Behaviour:
- Clock/reset: one clock CLOCK_50; reset synchronous, active-high, sampled on rising edge only.
- Reset: count = 0, prescaler = 0, wrap = 0; hex therefore shows "0" on every digit (7'b0000001 each) from the cycle after reset.
- Priority per cycle: reset > load > step > hold.
- Prescaler: counter 0..DIV-1, advances only when en=1; tick when en=1 and prescaler = DIV-1, prescaler then returns to 0. en=0 freezes prescaler (no clear). DIV=1: tick every cycle en=1; prescaler logic may be optimised away.
- Step (tick=1, load=0): up=1 -> digit 0 +1; a digit going 9->0 carries into the next. up=0 -> digit 0 -1; a digit going 0->9 borrows from the next. Ripple resolved combinationally within the cycle; count updates on the tick edge (latency 1 clock from tick).
- Wrap: up at all-9s -> all-0s, wrap=1 for that one cycle; down at all-0s -> all-9s, wrap=1. wrap=0 otherwise, including on load and reset.
- Load: count <= load_val next edge, prescaler cleared to 0. Any load digit >9 is clamped to 9 (count never holds non-BCD). Load with en=1 and pending tick: load wins, no step.
- up changing mid-count takes effect on the next tick; no glitch or extra step.
- hex is purely combinational from the count register (no extra latency); with DIGITS=1 only bits [6:0] exist.
- Reset mid-count or mid-prescale: all state cleared in the same edge, no pending tick survives.

Optional Feature:
LEADING_ZERO_BLANK_EN - when defined, every digit above digit 0 that is 0 and has only zeros above it drives 7'b1111111 (blank); digit 0 is never blanked. When undefined, all digits always show their value, zeros included. count and wrap unaffected either way.

Decomposition:
- Package bcd_disp_pkg: SEG_0..SEG_9 constants (0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100), SEG_BLANK=1111111, BCD_MAX=4'd9.
- Sub-module bcd_to_7seg: 4-bit BCD in, 7-bit active-low out, non-BCD input -> SEG_BLANK; instantiated DIGITS times via generate.

Test Plan:
- DIGITS=2, DIV=1: reset 3 cycles, then en=1 up=1 for 12 cycles -> count=8'h12, hex=[SEG_1,SEG_2], wrap never asserted.
- DIGITS=2: load 8'h99, up=1 one tick -> count=8'h00, wrap=1 exactly one cycle, next cycle wrap=0.
- DIGITS=2: load 8'h00, up=0 one tick -> count=8'h99, wrap=1 one cycle; further tick -> 8'h98.
- DIV=4: en=1 up=1 for 10 cycles from reset -> count=8'h02; drop en for 5 cycles -> count holds, prescaler resumes (2 more cycles -> 8'h03).
- load_val=8'hAF -> count=8'h99 (clamped); load and tick same cycle -> load value only, no step.
- LEADING_ZERO_BLANK_EN defined, DIGITS=3, count=12'h005 -> hex=[BLANK,BLANK,SEG_5]; count=12'h000 -> [BLANK,BLANK,SEG_0]; undefined -> [SEG_0,SEG_0,SEG_5].
